// File: rtl/window_3x3_gen.sv
// Raster-scan 3x3 neighbourhood generator feeding the Sobel window stage.
// Two line buffers hold the previous rows; the window shifts one column per pixel.
module window_3x3_gen #(
    parameter int WIDTH      = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] pixel_in,
    output logic [WIDTH-1:0] p1,
    output logic [WIDTH-1:0] p2,
    output logic [WIDTH-1:0] p3,
    output logic [WIDTH-1:0] p4,
    output logic [WIDTH-1:0] p5,
    output logic [WIDTH-1:0] p6,
    output logic [WIDTH-1:0] p7,
    output logic [WIDTH-1:0] p8,
    output logic [WIDTH-1:0] p9,
    output logic             valid,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]          r_col;
    logic [RW-1:0]          r_row;
    logic [8:0][WIDTH-1:0]  r_win;
    logic                   r_valid;
    logic                   r_done;
    logic [WIDTH-1:0]       r_lb0 [IMG_WIDTH];
    logic [WIDTH-1:0]       r_lb1 [IMG_WIDTH];

    logic                   w_col_last;
    logic                   w_row_last;
    logic                   w_interior;
    logic [WIDTH-1:0]       w_lb0_rd;
    logic [WIDTH-1:0]       w_lb1_rd;

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_interior = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_lb0_rd   = r_lb0[r_col];
    assign w_lb1_rd   = r_lb1[r_col];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col   <= '0;
            r_row   <= '0;
            r_win   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= en && w_interior;
            r_done  <= en && w_col_last && w_row_last;
            if (en) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_lb1_rd;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_lb0_rd;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= pixel_in;
            end
        end
    end

    // Not reset: a stray write while reset is held only touches rows that never go valid.
    always_ff @(posedge clk) begin
        if (en) begin
            r_lb1[r_col] <= w_lb0_rd;
            r_lb0[r_col] <= pixel_in;
        end
    end

    assign p1         = r_win[0];
    assign p2         = r_win[1];
    assign p3         = r_win[2];
    assign p4         = r_win[3];
    assign p5         = r_win[4];
    assign p6         = r_win[5];
    assign p7         = r_win[6];
    assign p8         = r_win[7];
    assign p9         = r_win[8];
    assign valid      = r_valid;
    assign frame_done = r_done;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen: a 4x4 instance and a 3x3 instance.
// Pixel values encode position as row*16+col (plus a frame base).
module tb_window_3x3_gen;

    logic       clk;
    logic       reset;
    logic       en_a;
    logic [7:0] pix_a;
    logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic       valid_a;
    logic       done_a;
    logic       en_b;
    logic [7:0] pix_b;
    logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
    logic       valid_b;
    logic       done_b;

    int n_assert;
    int n_fail;

    window_3x3_gen #(.WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .pixel_in(pix_a),
        .p1(a1), .p2(a2), .p3(a3), .p4(a4), .p5(a5),
        .p6(a6), .p7(a7), .p8(a8), .p9(a9),
        .valid(valid_a), .frame_done(done_a)
    );

    window_3x3_gen #(.WIDTH(8), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .pixel_in(pix_b),
        .p1(b1), .p2(b2), .p3(b3), .p4(b4), .p5(b5),
        .p6(b6), .p7(b7), .p8(b8), .p9(b9),
        .valid(valid_b), .frame_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [71:0] win_a = {a1, a2, a3, a4, a5, a6, a7, a8, a9};
    wire [71:0] win_b = {b1, b2, b3, b4, b5, b6, b7, b8, b9};

    // Expected window after accepting pixel (r,c) of a frame with base b.
    function automatic logic [71:0] exp_win(input int b, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], 8'(b + (r - 2 + i) * 16 + (c - 2 + j))};
        return w;
    endfunction

    task automatic push_a(input logic e, input logic [7:0] px);
        en_a  = e;
        pix_a = px;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        en_a = 1'b0; pix_a = '0;
        en_b = 1'b0; pix_b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if (win_a !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_win_a: got %h want 0", win_a);
        end
        n_assert++;
        if (valid_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags_a: got v=%b d=%b want 0 0", valid_a, done_a);
        end
        n_assert++;
        if (win_b !== 72'h0 || valid_b !== 1'b0 || done_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: got %h v=%b d=%b want 0", win_b, valid_b, done_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_continuous;
        int nv, nd;
        bit ev, ed;
        nv = 0; nd = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                push_a(1'b1, 8'(r * 16 + c));
                ev = (r >= 2) && (c >= 2);
                ed = (r == 3) && (c == 3);
                if (valid_a === 1'b1) nv++;
                if (done_a === 1'b1) nd++;
                n_assert++;
                if (valid_a !== ev || done_a !== ed) begin
                    n_fail++;
                    $display("FAIL cont_flags r%0d c%0d: got v=%b d=%b want v=%b d=%b",
                             r, c, valid_a, done_a, ev, ed);
                end
                if (ev) begin
                    n_assert++;
                    if (win_a !== exp_win(0, r, c)) begin
                        n_fail++;
                        $display("FAIL cont_win r%0d c%0d: got %h want %h",
                                 r, c, win_a, exp_win(0, r, c));
                    end
                end
                if (r == 2 && c == 2) begin
                    n_assert++;
                    if (win_a !== 72'h00_01_02_10_11_12_20_21_22) begin
                        n_fail++;
                        $display("FAIL first_window: got %h want 000102101112202122", win_a);
                    end
                end
                if (r == 2 && c == 3) begin
                    n_assert++;
                    if (win_a !== 72'h01_02_03_11_12_13_21_22_23) begin
                        n_fail++;
                        $display("FAIL second_window: got %h want 010203111213212223", win_a);
                    end
                end
            end
        end
        push_a(1'b0, 8'h00);
        n_assert++;
        if (nv != 4 || nd != 1) begin
            n_fail++;
            $display("FAIL cont_counts: got valid=%0d done=%0d want 4 1", nv, nd);
        end
    endtask

    task automatic test_en_toggle;
        int nv;
        bit ev;
        nv = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                push_a(1'b1, 8'(r * 16 + c));
                ev = (r >= 2) && (c >= 2);
                if (valid_a === 1'b1) nv++;
                n_assert++;
                if (valid_a !== ev || (ev && win_a !== exp_win(0, r, c))) begin
                    n_fail++;
                    $display("FAIL toggle_on r%0d c%0d: got v=%b %h want v=%b %h",
                             r, c, valid_a, win_a, ev, exp_win(0, r, c));
                end
                push_a(1'b0, 8'hEE);
                n_assert++;
                if (valid_a !== 1'b0 || done_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL toggle_gap_flags r%0d c%0d: got v=%b d=%b want 0 0",
                             r, c, valid_a, done_a);
                end
                if (ev) begin
                    n_assert++;
                    if (win_a !== exp_win(0, r, c)) begin
                        n_fail++;
                        $display("FAIL toggle_hold r%0d c%0d: got %h want %h",
                                 r, c, win_a, exp_win(0, r, c));
                    end
                end
            end
        end
        n_assert++;
        if (nv != 4) begin
            n_fail++;
            $display("FAIL toggle_count: got %0d want 4", nv);
        end
    endtask

    task automatic test_back_to_back;
        int nv2;
        bit ev;
        nv2 = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    push_a(1'b1, 8'(f * 8'h80 + r * 16 + c));
                    ev = (r >= 2) && (c >= 2);
                    if (f == 1 && valid_a === 1'b1) nv2++;
                    if (f == 1 && r < 2) begin
                        n_assert++;
                        if (valid_a !== 1'b0) begin
                            n_fail++;
                            $display("FAIL b2b_border r%0d c%0d: got v=%b want 0", r, c, valid_a);
                        end
                    end
                    if (f == 1 && r == 2 && c == 2) begin
                        n_assert++;
                        if (valid_a !== 1'b1 || win_a !== 72'h80_81_82_90_91_92_A0_A1_A2) begin
                            n_fail++;
                            $display("FAIL b2b_first: got v=%b %h want 1 808182909192a0a1a2",
                                     valid_a, win_a);
                        end
                    end
                    if (f == 1 && ev) begin
                        n_assert++;
                        if (win_a !== exp_win(8'h80, r, c)) begin
                            n_fail++;
                            $display("FAIL b2b_win r%0d c%0d: got %h want %h",
                                     r, c, win_a, exp_win(8'h80, r, c));
                        end
                    end
                end
            end
        end
        push_a(1'b0, 8'h00);
        n_assert++;
        if (nv2 != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 4", nv2);
        end
    endtask

    task automatic test_reset_midframe;
        int nv;
        bit ev;
        for (int k = 0; k < 10; k++)
            push_a(1'b1, 8'((k / 4) * 16 + (k % 4)));
        n_assert++;
        if (win_a === 72'h0) begin
            n_fail++;
            $display("FAIL midreset_pre: got %h want nonzero window", win_a);
        end
        #2;
        reset = 1'b1;
        #1;
        n_assert++;
        if (win_a !== 72'h0 || valid_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got %h v=%b d=%b want 0", win_a, valid_a, done_a);
        end
        en_a = 1'b1;
        pix_a = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if (win_a !== 72'h0 || valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_en_ignored: got %h v=%b want 0", win_a, valid_a);
        end
        en_a = 1'b0;
        reset = 1'b0;
        nv = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                push_a(1'b1, 8'(r * 16 + c));
                ev = (r >= 2) && (c >= 2);
                if (valid_a === 1'b1) nv++;
                n_assert++;
                if (valid_a !== ev || (ev && win_a !== exp_win(0, r, c))) begin
                    n_fail++;
                    $display("FAIL postreset r%0d c%0d: got v=%b %h want v=%b %h",
                             r, c, valid_a, win_a, ev, exp_win(0, r, c));
                end
            end
        end
        push_a(1'b0, 8'h00);
        n_assert++;
        if (nv != 4) begin
            n_fail++;
            $display("FAIL postreset_count: got %0d want 4", nv);
        end
    endtask

    task automatic test_small;
        int nv;
        bit last;
        nv = 0;
        en_a = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                en_b = 1'b1;
                pix_b = 8'(r * 16 + c);
                @(posedge clk);
                #1;
                last = (r == 2) && (c == 2);
                if (valid_b === 1'b1) nv++;
                n_assert++;
                if (valid_b !== last || done_b !== last) begin
                    n_fail++;
                    $display("FAIL small_flags r%0d c%0d: got v=%b d=%b want %b %b",
                             r, c, valid_b, done_b, last, last);
                end
                if (last) begin
                    n_assert++;
                    if (win_b !== 72'h00_01_02_10_11_12_20_21_22) begin
                        n_fail++;
                        $display("FAIL small_win: got %h want 000102101112202122", win_b);
                    end
                end
            end
        end
        en_b = 1'b0;
        @(posedge clk);
        #1;
        n_assert++;
        if (nv != 1 || valid_b !== 1'b0 || done_b !== 1'b0) begin
            n_fail++;
            $display("FAIL small_count: got %0d v=%b d=%b want 1 0 0", nv, valid_b, done_b);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        test_reset();
        test_continuous();
        test_en_toggle();
        test_back_to_back();
        test_reset_midframe();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
